// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - fetch/decode instruction buffer, FWFT valid/ready queue with one-cycle flush
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              if_ready,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  input  logic              id_ready,
  input  logic              flush,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic [PTR_W-1:0]  r_wp;
  logic [PTR_W-1:0]  r_rp;
  logic [CNT_W-1:0]  r_count;

  logic w_push;
  logic w_pop;

  // Handshake flags depend on registered occupancy only, so no input reaches an output.
  assign if_ready = (r_count != FULL);
  assign id_valid = (r_count != '0);
  assign w_push   = if_valid && if_ready;
  assign w_pop    = id_valid && id_ready;

  assign id_pc   = id_valid ? r_pc_mem[r_rp]   : '0;
  assign id_inst = id_valid ? r_inst_mem[r_rp] : '0;
  assign count   = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_inst_mem[i] <= '0;
      end
    end else if (flush) begin
      // Stale storage is left in place; it is unreachable once count is zero.
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc_mem[r_wp]   <= if_pc;
        r_inst_mem[r_wp] <= if_inst;
        r_wp             <= r_wp + PTR_W'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - scoreboard bench for if_id_queue
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_inst = '0;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_ready(id_ready),
    .flush(flush), .count(count)
  );

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return {~pc[15:0], pc[15:0]} ^ 32'hA5A5_0013;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [31:0] pc, input bit expect_accept);
    ent_t e;
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = mk_inst(pc);
    if (expect_accept) begin
      e.pc   = pc;
      e.inst = mk_inst(pc);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every accepted pop is checked against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && !flush && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected: got pc 0x%0h expected no entry", id_pc);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        check("pop_pc", 64'(id_pc), 64'(e.pc));
        check("pop_inst", 64'(id_inst), 64'(e.inst));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset
    #2 rst = 1'b1;
    #20 rst = 1'b0;
    #1;
    check("rst_if_ready", 64'(if_ready), 64'd1);
    check("rst_id_valid", 64'(id_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_id_pc", 64'(id_pc), 64'd0);
    check("rst_id_inst", 64'(id_inst), 64'd0);

    // Push into empty queue: visible only after the edge
    step();
    drive_push(32'h40, 1'b1);
    #1 check("empty_push_same_cycle_valid", 64'(id_valid), 64'd0);
    step();
    if_valid = 1'b0;
    check("empty_push_next_valid", 64'(id_valid), 64'd1);
    check("empty_push_next_pc", 64'(id_pc), 64'h40);
    check("empty_push_count", 64'(count), 64'd1);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    check("empty_drain_count", 64'(count), 64'd0);
    check("empty_drain_pc_zero", 64'(id_pc), 64'd0);

    // Fill to DEPTH with decode stalled, then a refused fifth push
    for (int i = 0; i < 4; i++) begin
      drive_push(32'(i * 4), 1'b1);
      step();
    end
    check("full_count", 64'(count), 64'd4);
    check("full_if_ready", 64'(if_ready), 64'd0);
    drive_push(32'h10, 1'b0);
    step();
    if_valid = 1'b0;
    check("full_fifth_count", 64'(count), 64'd4);
    id_ready = 1'b1;
    repeat (4) step();
    id_ready = 1'b0;
    check("drain_count", 64'(count), 64'd0);
    check("drain_id_valid", 64'(id_valid), 64'd0);

    // Streaming at count=1
    drive_push(32'h100, 1'b1);
    step();
    for (int k = 0; k < 20; k++) begin
      drive_push(32'h104 + 32'(4 * k), 1'b1);
      id_ready = 1'b1;
      step();
      check("stream_count", 64'(count), 64'd1);
    end
    if_valid = 1'b0;
    step();
    id_ready = 1'b0;
    check("stream_end_count", 64'(count), 64'd0);

    // Alternating push/pop pairs so both pointers wrap
    for (int k = 0; k < 10; k++) begin
      drive_push(32'h1000 + 32'(k * 8), 1'b1);
      id_ready = 1'b0;
      step();
      if_valid = 1'b0;
      id_ready = 1'b1;
      step();
    end
    id_ready = 1'b0;
    check("wrap_count", 64'(count), 64'd0);

    // Flush collides with push and pop
    for (int i = 0; i < 3; i++) begin
      drive_push(32'h200 + 32'(i * 4), 1'b1);
      step();
    end
    if_valid = 1'b0;
    check("preflush_count", 64'(count), 64'd3);
    flush = 1'b1;
    drive_push(32'h300, 1'b0);
    id_ready = 1'b1;
    exp_q.delete();
    step();
    flush = 1'b0;
    if_valid = 1'b0;
    id_ready = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_id_valid", 64'(id_valid), 64'd0);
    check("flush_if_ready", 64'(if_ready), 64'd1);
    drive_push(32'h400, 1'b1);
    step();
    if_valid = 1'b0;
    check("postflush_pc", 64'(id_pc), 64'h400);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;

    // Asynchronous reset mid-cycle with two entries held
    drive_push(32'h500, 1'b1);
    step();
    drive_push(32'h504, 1'b1);
    step();
    if_valid = 1'b0;
    check("prerst_count", 64'(count), 64'd2);
    @(negedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_id_valid", 64'(id_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_if_ready", 64'(if_ready), 64'd1);
    check("arst_id_pc", 64'(id_pc), 64'd0);
    check("arst_id_inst", 64'(id_inst), 64'd0);
    #10 rst = 1'b0;
    step();
    drive_push(32'h600, 1'b1);
    step();
    if_valid = 1'b0;
    check("resume_pc", 64'(id_pc), 64'h600);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
